data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder end of the datapath's data-memory access interface.
- Accepts load/store requests (address, size, write data) from the uDATAPATH memory port and serves them from an internal word-organised RAM, with a configurable number of wait states.
- Returns read data together with a one-cycle acknowledge; flags misaligned, illegal-size and out-of-range accesses with an error pulse.
- Sits beside uDATAPATH under WB_uProcesador.

Parameters:
- DATAWIDTH_BUS, 32, data and address bus width.
- DATAWIDTH_MEM_ADDR, 10, word-address width; RAM depth is 2^DATAWIDTH_MEM_ADDR words.
- DATAWIDTH_SIZE, 2, access-size field width.
- DATAWIDTH_WAIT, 4, wait-state counter width.
- WAIT_STATES, 2, extra cycles inserted before ack (0..2^DATAWIDTH_WAIT-1).

Ports:
- DataMemory_CLOCK_50  in  1  single clock, rising edge.
- DataMemory_Reset_InHigh  in  1  synchronous reset, active-high.
- DataMemory_Req_In  in  1  request; held high by the initiator until ack.
- DataMemory_Write_In  in  1  1 = store, 0 = load; sampled at acceptance.
- DataMemory_Size_In  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- DataMemory_Address_In  in  32  byte address.
- DataMemory_Data_In  in  32  store data, right-justified.
- DataMemory_Data_Out  out  32  load data, zero-extended, right-justified.
- DataMemory_Ack_Out  out  1  one-cycle completion pulse.
- DataMemory_Error_Out  out  1  one-cycle pulse coincident with ack on a faulted access.
- DataMemory_Busy_Out  out  1  high in WAIT and ACK states.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: FSM to IDLE; Data_Out = 0, Ack_Out = 0, Error_Out = 0, Busy_Out = 0; wait counter = 0; any latched transaction is discarded. RAM contents are not cleared.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - Req_In = 1 latches Write, Size, Address and Data, then checks faults.
  - WAIT_STATES = 0 goes straight to ACK; otherwise goes to WAIT with the counter loaded to WAIT_STATES-1.
- WAIT:
  - Counter decrements each cycle; at 0, go to ACK.
  - Req_In falling to 0 here aborts: back to IDLE, no RAM write, no ack.
- ACK (one cycle):
  - Ack_Out = 1. Store commits to RAM on this edge. Load data is valid on Data_Out from this cycle and holds until the next ack.
  - Next state is always IDLE.
- Latency: acceptance at cycle N gives Ack_Out high at cycle N+1+WAIT_STATES.
- Handshake: the initiator drops Req_In in the cycle after ack. A Req_In still high in IDLE is accepted as a new transaction, so back-to-back throughput is one access per 2+WAIT_STATES cycles.
- Endianness: big-endian. Byte offset 0 maps to bits 31:24 of the RAM word.
  - Byte store at offset k writes bits [31-8k:24-8k] and leaves the other lanes unchanged (read-modify-write on the latched word).
  - Halfword offsets 0/2 use bits 31:16 / 15:0.
- Faults (error and ack pulse together, no RAM write, Data_Out unchanged):
  - halfword with Address[0] = 1;
  - word with Address[1:0] != 0;
  - Size = 11;
  - Address[31:DATAWIDTH_MEM_ADDR+2] != 0 (out of range).
- Faulted accesses still pass through WAIT, so latency is uniform.
- Word index: Address[DATAWIDTH_MEM_ADDR+1:2].
- Input changes during WAIT are ignored (only the latched copy is used), except Req_In for abort.
- Reset asserted in WAIT or ACK: IDLE on the next edge, no write, no ack.

Decomposition:
- Shared package holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_ILLEGAL;
  - FSM state encodings;
  - a lane-mask function from (size, offset) to a 4-bit byte-enable.
- One natural sub-module, data_memory_ram: single-port synchronous RAM with 4-bit byte enables and registered read.
  - It is read during WAIT/acceptance so the word is available for the ACK-cycle merge. With WAIT_STATES = 0, the RAM read issues at acceptance and its output is used in ACK.

Test Plan:
- Reset, then WAIT_STATES = 2: store word 0xDEADBEEF at 0x00000010, then load the same address. Ack occurs 3 cycles after each acceptance; Data_Out = 0xDEADBEEF; Error_Out = 0.
- Byte store 0xAA at 0x11, then word load at 0x10. Result is 0xDEAABEEF. Halfword load at 0x12 returns 0x0000BEEF.
- Word load at 0x12, halfword at 0x13, Size = 11, and address 0x00001000 with DATAWIDTH_MEM_ADDR = 10: each gives Ack = 1 and Error = 1 in the same cycle, RAM is unchanged, and Data_Out keeps its prior value.
- Req_In dropped in the first WAIT cycle of a store of 0x12345678 to 0x20: no ack. A subsequent load of 0x20 returns the old value (0 after reset-initialised bench preload).
- Req_In held high through ack with WAIT_STATES = 0: a second transaction is accepted in the cycle after ack. Acks are spaced exactly 2 cycles apart.
- Reset asserted in the WAIT of a store to 0x30: Busy_Out = 0 and no ack on the next cycle. A later load of 0x30 shows the RAM unmodified.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the big-endian byte-lane mask.
package data_memory_responder_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Byte offset 0 is the most significant lane (bits 31:24), hence mask bit 3.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b1000 >> offset;
      SIZE_HALF: mask = offset[1] ? 4'b0011 : 4'b1100;
      SIZE_WORD: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/data_memory_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are never cleared; a write and a read to the same word return the old data.
module data_memory_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/data_memory_responder.sv
// Responder for the datapath data-memory port: latches a request, waits
// WAIT_STATES cycles, then acks (with error on faulted accesses).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for Req_In; RAM is addressed straight from the bus
//   ST_WAIT | counting wait states on the latched request; Req_In low aborts
//   ST_ACK  | one-cycle ack/error; stores commit, loads drive Data_Out
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DATAWIDTH_BUS      = 32,
  parameter int DATAWIDTH_MEM_ADDR = 10,
  parameter int DATAWIDTH_SIZE     = 2,
  parameter int DATAWIDTH_WAIT     = 4,
  parameter int WAIT_STATES        = 2
) (
  input  logic                      DataMemory_CLOCK_50,
  input  logic                      DataMemory_Reset_InHigh,
  input  logic                      DataMemory_Req_In,
  input  logic                      DataMemory_Write_In,
  input  logic [DATAWIDTH_SIZE-1:0] DataMemory_Size_In,
  input  logic [DATAWIDTH_BUS-1:0]  DataMemory_Address_In,
  input  logic [DATAWIDTH_BUS-1:0]  DataMemory_Data_In,
  output logic [DATAWIDTH_BUS-1:0]  DataMemory_Data_Out,
  output logic                      DataMemory_Ack_Out,
  output logic                      DataMemory_Error_Out,
  output logic                      DataMemory_Busy_Out
);

  localparam int MEM_HI = DATAWIDTH_MEM_ADDR + 1;
  localparam logic [DATAWIDTH_WAIT-1:0] WAIT_LOAD =
    (WAIT_STATES == 0) ? '0 : DATAWIDTH_WAIT'(WAIT_STATES - 1);

  state_t                      r_state;
  logic                        r_write;
  logic [DATAWIDTH_SIZE-1:0]   r_size;
  logic [MEM_HI:0]             r_addr;
  logic [DATAWIDTH_BUS-1:0]    r_wdata;
  logic                        r_fault;
  logic [DATAWIDTH_WAIT-1:0]   r_wait_cnt;
  logic [DATAWIDTH_BUS-1:0]    r_data_out;
  logic                        r_ack;
  logic                        r_error;
  logic                        r_busy;

  logic                          w_fault;
  logic                          w_we;
  logic                          w_load_ack;
  logic [DATAWIDTH_MEM_ADDR-1:0] w_ram_addr;
  logic [3:0]                    w_be;
  logic [DATAWIDTH_BUS-1:0]      w_ram_wdata;
  logic [DATAWIDTH_BUS-1:0]      w_ram_rdata;
  logic [DATAWIDTH_BUS-1:0]      w_load_data;

  always_comb begin
    w_fault = 1'b0;
    case (DataMemory_Size_In)
      SIZE_HALF:    w_fault = DataMemory_Address_In[0];
      SIZE_WORD:    w_fault = |DataMemory_Address_In[1:0];
      SIZE_ILLEGAL: w_fault = 1'b1;
      default:      w_fault = 1'b0;
    endcase
    if (|DataMemory_Address_In[DATAWIDTH_BUS-1:MEM_HI+1]) w_fault = 1'b1;
  end

  // In IDLE the RAM reads the bus address so the word is ready even with no wait states.
  assign w_ram_addr = (r_state == ST_IDLE) ? DataMemory_Address_In[MEM_HI:2] : r_addr[MEM_HI:2];
  assign w_be       = lane_mask(r_size, r_addr[1:0]);
  assign w_we       = (r_state == ST_ACK) && r_write && !r_fault && !DataMemory_Reset_InHigh;
  assign w_ram_wdata = (r_size == SIZE_BYTE) ? {4{r_wdata[7:0]}} :
                       (r_size == SIZE_HALF) ? {2{r_wdata[15:0]}} : r_wdata;

  always_comb begin
    w_load_data = '0;
    case (r_size)
      SIZE_BYTE: w_load_data[7:0]  = 8'(w_ram_rdata >> {~r_addr[1:0], 3'b000});
      SIZE_HALF: w_load_data[15:0] = 16'(w_ram_rdata >> {~r_addr[1], 4'b0000});
      default:   w_load_data       = w_ram_rdata;
    endcase
  end

  data_memory_ram #(.ADDR_W(DATAWIDTH_MEM_ADDR)) u_ram (
    .i_clk   (DataMemory_CLOCK_50),
    .i_addr  (w_ram_addr),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge DataMemory_CLOCK_50) begin
    if (DataMemory_Reset_InHigh) begin
      r_state    <= ST_IDLE;
      r_write    <= 1'b0;
      r_size     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_fault    <= 1'b0;
      r_wait_cnt <= '0;
      r_data_out <= '0;
      r_ack      <= 1'b0;
      r_error    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (DataMemory_Req_In) begin
            r_write <= DataMemory_Write_In;
            r_size  <= DataMemory_Size_In;
            r_addr  <= DataMemory_Address_In[MEM_HI:0];
            r_wdata <= DataMemory_Data_In;
            r_fault <= w_fault;
            r_busy  <= 1'b1;
            if (WAIT_STATES == 0) begin
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
              r_error <= w_fault;
            end else begin
              r_state    <= ST_WAIT;
              r_wait_cnt <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (!DataMemory_Req_In) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_wait_cnt == '0) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
            r_error <= r_fault;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
          r_error <= 1'b0;
          r_busy  <= 1'b0;
          if (!r_write && !r_fault) r_data_out <= w_load_data;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
          r_error <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The registered RAM word only lands in the ACK cycle, so loads bypass r_data_out there.
  assign w_load_ack          = (r_state == ST_ACK) && !r_write && !r_fault;
  assign DataMemory_Data_Out = w_load_ack ? w_load_data : r_data_out;
  assign DataMemory_Ack_Out   = r_ack;
  assign DataMemory_Error_Out = r_error;
  assign DataMemory_Busy_Out  = r_busy;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance with two wait states,
// one with none for the back-to-back handshake.
module tb_data_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_req, a_write;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_ack, a_err, a_busy;
  logic        b_req, b_write;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_ack, b_err, b_busy;

  int n_tests = 0;
  int n_fail  = 0;

  data_memory_responder #(.WAIT_STATES(2)) u_dut_w2 (
    .DataMemory_CLOCK_50     (clk),
    .DataMemory_Reset_InHigh (rst),
    .DataMemory_Req_In       (a_req),
    .DataMemory_Write_In     (a_write),
    .DataMemory_Size_In      (a_size),
    .DataMemory_Address_In   (a_addr),
    .DataMemory_Data_In      (a_wdata),
    .DataMemory_Data_Out     (a_rdata),
    .DataMemory_Ack_Out      (a_ack),
    .DataMemory_Error_Out    (a_err),
    .DataMemory_Busy_Out     (a_busy)
  );

  data_memory_responder #(.WAIT_STATES(0)) u_dut_w0 (
    .DataMemory_CLOCK_50     (clk),
    .DataMemory_Reset_InHigh (rst),
    .DataMemory_Req_In       (b_req),
    .DataMemory_Write_In     (b_write),
    .DataMemory_Size_In      (b_size),
    .DataMemory_Address_In   (b_addr),
    .DataMemory_Data_In      (b_wdata),
    .DataMemory_Data_Out     (b_rdata),
    .DataMemory_Ack_Out      (b_ack),
    .DataMemory_Error_Out    (b_err),
    .DataMemory_Busy_Out     (b_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one request on the 2-wait-state instance; lat counts edges from request to ack.
  task automatic access(input logic wr, input logic [1:0] sz, input logic [31:0] ad,
                        input logic [31:0] wd, output int lat, output logic err,
                        output logic [31:0] dat, output logic busy);
    a_write = wr; a_size = sz; a_addr = ad; a_wdata = wd; a_req = 1'b1;
    lat = -1; err = 1'b0; dat = '0; busy = 1'b0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (a_ack) begin
        lat = c; err = a_err; dat = a_rdata; busy = a_busy;
      end
    end
    a_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic op(input string tag, input logic wr, input logic [1:0] sz,
                    input logic [31:0] ad, input logic [31:0] wd, input logic exp_err,
                    input logic chk_data, input logic [31:0] exp_data);
    int          lat;
    logic        err, busy;
    logic [31:0] dat;
    access(wr, sz, ad, wd, lat, err, dat, busy);
    check_eq({tag, "_lat"}, lat, 32'd3);
    check_eq({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
    if (chk_data) check_eq({tag, "_data"}, dat, exp_data);
  endtask

  initial begin
    int acks, ack1, ack2;
    logic [31:0] dat2;
    logic        err2;

    rst = 1'b1;
    a_req = 0; a_write = 0; a_size = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_write = 0; b_size = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", a_rdata, 32'h0);
    check_eq("rst_ack",  {31'd0, a_ack}, 32'd0);
    check_eq("rst_err",  {31'd0, a_err}, 32'd0);
    check_eq("rst_busy", {31'd0, a_busy}, 32'd0);
    check_eq("rst_w0_data", b_rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    op("pre20", 1'b1, 2'b10, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0);
    op("pre30", 1'b1, 2'b10, 32'h30, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);

    op("st10",   1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    op("ld10",   1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    op("stb11",  1'b1, 2'b00, 32'h11, 32'h123456AA, 1'b0, 1'b0, 32'h0);
    op("ld10b",  1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAABEEF);
    op("ldh12",  1'b0, 2'b01, 32'h12, 32'h0, 1'b0, 1'b1, 32'h0000BEEF);
    op("ldb13",  1'b0, 2'b00, 32'h13, 32'h0, 1'b0, 1'b1, 32'h000000EF);
    op("ldh10",  1'b0, 2'b01, 32'h10, 32'h0, 1'b0, 1'b1, 32'h0000DEAA);

    // faulted accesses: error with ack, Data_Out keeps the last load, RAM untouched
    op("f_ldw12",   1'b0, 2'b10, 32'h12, 32'h0, 1'b1, 1'b1, 32'h0000DEAA);
    op("f_ldh13",   1'b0, 2'b01, 32'h13, 32'h0, 1'b1, 1'b1, 32'h0000DEAA);
    op("f_size3",   1'b0, 2'b11, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0000DEAA);
    op("f_range",   1'b0, 2'b10, 32'h1000, 32'h0, 1'b1, 1'b1, 32'h0000DEAA);
    op("f_stw12",   1'b1, 2'b10, 32'h12, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0000DEAA);
    op("f_st_sz3",  1'b1, 2'b11, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0000DEAA);
    op("f_st_rng",  1'b1, 2'b10, 32'h1010, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0000DEAA);
    op("ld10_after_faults", 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAABEEF);

    // abort: Req_In dropped in the first WAIT cycle
    a_write = 1'b1; a_size = 2'b10; a_addr = 32'h20; a_wdata = 32'h12345678; a_req = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_busy_wait", {31'd0, a_busy}, 32'd1);
    a_req = 1'b0;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 0) check_eq("abort_busy_idle", {31'd0, a_busy}, 32'd0);
      if (a_ack) acks++;
    end
    check_eq("abort_no_ack", acks, 32'd0);
    op("abort_ld20", 1'b0, 2'b10, 32'h20, 32'h0, 1'b0, 1'b1, 32'h0);

    // reset during WAIT of a store; Req_In stays high across the reset edge
    a_write = 1'b1; a_size = 2'b10; a_addr = 32'h30; a_wdata = 32'h11111111; a_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rstw_busy", {31'd0, a_busy}, 32'd0);
    check_eq("rstw_ack",  {31'd0, a_ack}, 32'd0);
    rst = 1'b0; a_req = 1'b0;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (a_ack) acks++;
    end
    check_eq("rstw_no_ack", acks, 32'd0);
    op("rstw_ld30", 1'b0, 2'b10, 32'h30, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);

    // zero wait states, Req_In held through ack: store then load back-to-back
    b_write = 1'b1; b_size = 2'b10; b_addr = 32'h40; b_wdata = 32'h5A5AA5A5; b_req = 1'b1;
    ack1 = -1; ack2 = -1; dat2 = '0; err2 = 1'b1;
    for (int c = 1; c <= 12 && ack2 < 0; c++) begin
      @(posedge clk); #1;
      if (b_ack) begin
        if (ack1 < 0) begin
          ack1 = c;
          b_write = 1'b0;
        end else begin
          ack2 = c; dat2 = b_rdata; err2 = b_err;
        end
      end
    end
    b_req = 1'b0;
    check_eq("b2b_ack1", ack1, 32'd1);
    check_eq("b2b_ack2", ack2, 32'd3);
    check_eq("b2b_data", dat2, 32'h5A5AA5A5);
    check_eq("b2b_err",  {31'd0, err2}, 32'd0);
    @(posedge clk); #1;
    check_eq("b2b_idle_ack", {31'd0, b_ack}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
